// File: rtl/ifc_or_sink.sv
// Consumer stage for the OR-gate block: pulls results from the producer's y method,
// buffers them in a DEPTH-entry FIFO drained through deq, and keeps saturating result statistics.
module ifc_or_sink #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             y_data,
    input  logic             y_rdy,
    output logic             y_en,
    output logic             deq_data,
    output logic             deq_rdy,
    input  logic             deq_en,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] total_count,
    output logic [CNT_W-1:0] ones_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             enq;
    logic             deq;

    // RST_N is active-high despite its name; it also gates the take strobe.
    assign enq      = y_rdy & ~full & ~RST_N;
    assign deq      = deq_en & deq_rdy;
    assign y_en     = enq;
    assign empty    = (occ == OCC_W'(0));
    assign full     = (occ == OCC_W'(DEPTH));
    assign deq_rdy  = ~empty;
    assign deq_data = mem[rd_ptr];

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= y_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Statistics counters saturate at all-ones and ignore dequeues.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            total_count <= '0;
            ones_count  <= '0;
        end else if (enq) begin
            if (total_count != '1) begin
                total_count <= total_count + CNT_W'(1);
            end
            if (y_data && (ones_count != '1)) begin
                ones_count <= ones_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifc_or_sink.sv
// Directed bench for ifc_or_sink (DEPTH=4, CNT_W=4): reset, ordering, wrap, full/empty edges, saturation.
module tb_ifc_or_sink;

    logic       CLK;
    logic       RST_N;
    logic       y_data;
    logic       y_rdy;
    logic       y_en;
    logic       deq_data;
    logic       deq_rdy;
    logic       deq_en;
    logic       full;
    logic       empty;
    logic [3:0] total_count;
    logic [3:0] ones_count;

    int vectors;
    int errors;

    ifc_or_sink #(.DEPTH(4), .CNT_W(4)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .y_data      (y_data),
        .y_rdy       (y_rdy),
        .y_en        (y_en),
        .deq_data    (deq_data),
        .deq_rdy     (deq_rdy),
        .deq_en      (deq_en),
        .full        (full),
        .empty       (empty),
        .total_count (total_count),
        .ones_count  (ones_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N  = 1'b1;
        y_rdy  = 1'b0;
        y_data = 1'b0;
        deq_en = 1'b0;
        cyc();
        cyc();
        RST_N = 1'b0;
    endtask

    task automatic test_reset();
        RST_N  = 1'b1;
        y_rdy  = 1'b1;
        y_data = 1'b1;
        deq_en = 1'b0;
        cyc();
        cyc();
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
        vectors++; if (deq_rdy !== 1'b0) begin errors++; $display("FAIL rst_deq_rdy: got %b expected 0", deq_rdy); end
        vectors++; if (deq_data !== 1'b0) begin errors++; $display("FAIL rst_deq_data: got %b expected 0", deq_data); end
        vectors++; if (y_en !== 1'b0) begin errors++; $display("FAIL rst_y_en: got %b expected 0", y_en); end
        vectors++; if (total_count !== 4'd0 || ones_count !== 4'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", total_count, ones_count); end
        y_rdy  = 1'b0;
        RST_N  = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [2:0] pat;
        pat = 3'b101;
        for (int i = 0; i < 3; i++) begin
            y_rdy  = 1'b1;
            y_data = pat[i];
            cyc();
        end
        y_rdy = 1'b0;
        vectors++; if (total_count !== 4'd3 || ones_count !== 4'd2) begin errors++; $display("FAIL mid_pre_counts: got %0d/%0d expected 3/2", total_count, ones_count); end
        vectors++; if (deq_data !== 1'b1 || deq_rdy !== 1'b1) begin errors++; $display("FAIL mid_pre_head: got %b/%b expected 1/1", deq_data, deq_rdy); end
        y_rdy = 1'b1;
        #2;
        RST_N = 1'b1;
        #1;
        vectors++; if (empty !== 1'b1 || deq_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_empty: got empty=%b deq_rdy=%b expected 1/0", empty, deq_rdy); end
        vectors++; if (y_en !== 1'b0) begin errors++; $display("FAIL mid_rst_y_en: got %b expected 0", y_en); end
        vectors++; if (total_count !== 4'd0 || ones_count !== 4'd0) begin errors++; $display("FAIL mid_rst_counts: got %0d/%0d expected 0/0", total_count, ones_count); end
        cyc();
        RST_N  = 1'b0;
        y_rdy  = 1'b1;
        y_data = 1'b1;
        #1;
        vectors++; if (y_en !== 1'b1) begin errors++; $display("FAIL mid_rel_y_en: got %b expected 1", y_en); end
        cyc();
        y_rdy = 1'b0;
        vectors++; if (deq_data !== 1'b1 || deq_rdy !== 1'b1) begin errors++; $display("FAIL mid_rel_first: got %b/%b expected 1/1", deq_data, deq_rdy); end
        vectors++; if (total_count !== 4'd1 || ones_count !== 4'd1) begin errors++; $display("FAIL mid_rel_counts: got %0d/%0d expected 1/1", total_count, ones_count); end
        deq_en = 1'b1;
        cyc();
        deq_en = 1'b0;
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_fill_drain();
        logic [3:0] pat;
        pat = 4'b1101;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            y_rdy  = 1'b1;
            y_data = pat[i];
            #1;
            vectors++; if (y_en !== 1'b1) begin errors++; $display("FAIL fill_y_en[%0d]: got %b expected 1", i, y_en); end
            cyc();
        end
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
        vectors++; if (y_en !== 1'b0) begin errors++; $display("FAIL fill_y_en_full: got %b expected 0", y_en); end
        y_rdy  = 1'b0;
        deq_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (deq_data !== pat[i]) begin errors++; $display("FAIL drain_data[%0d]: got %b expected %b", i, deq_data, pat[i]); end
            cyc();
        end
        deq_en = 1'b0;
        vectors++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL drain_empty: got empty=%b full=%b expected 1/0", empty, full); end
    endtask

    task automatic test_wrap();
        logic exp_bit;
        do_reset();
        y_rdy  = 1'b1;
        y_data = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++) begin
            y_data  = ((i + 1) % 2 == 1);
            deq_en  = 1'b1;
            exp_bit = (i % 2 == 1);
            #1;
            vectors++; if (deq_data !== exp_bit || deq_rdy !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL wrap[%0d]: got data=%b rdy=%b full=%b expected %b/1/0", i, deq_data, deq_rdy, full, exp_bit); end
            cyc();
        end
        y_rdy  = 1'b0;
        deq_en = 1'b0;
        vectors++; if (deq_rdy !== 1'b1 || deq_data !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL wrap_tail: got rdy=%b data=%b full=%b expected 1/0/0", deq_rdy, deq_data, full); end
        deq_en = 1'b1;
        cyc();
        deq_en = 1'b0;
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic test_full_pop();
        logic [3:0] exp_out;
        exp_out = 4'b1101;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            y_rdy  = 1'b1;
            y_data = (i % 2 == 1);
            cyc();
        end
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL fp_full: got %b expected 1", full); end
        y_data = 1'b1;
        deq_en = 1'b1;
        #1;
        vectors++; if (y_en !== 1'b0 || deq_data !== 1'b0) begin errors++; $display("FAIL fp_same_cycle: got y_en=%b data=%b expected 0/0", y_en, deq_data); end
        cyc();
        deq_en = 1'b0;
        #1;
        vectors++; if (y_en !== 1'b1 || full !== 1'b0 || deq_data !== 1'b1) begin errors++; $display("FAIL fp_next_cycle: got y_en=%b full=%b data=%b expected 1/0/1", y_en, full, deq_data); end
        cyc();
        y_rdy = 1'b0;
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL fp_refull: got %b expected 1", full); end
        deq_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (deq_data !== exp_out[i]) begin errors++; $display("FAIL fp_drain[%0d]: got %b expected %b", i, deq_data, exp_out[i]); end
            cyc();
        end
        deq_en = 1'b0;
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL fp_empty: got %b expected 1", empty); end
    endtask

    // Runs straight after test_full_pop: rd_ptr sits at 1, whose slot holds a stale 1.
    task automatic test_empty_pop();
        y_rdy  = 1'b0;
        deq_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors++; if (empty !== 1'b1 || deq_rdy !== 1'b0 || deq_data !== 1'b1) begin errors++; $display("FAIL ep_hold[%0d]: got empty=%b rdy=%b data=%b expected 1/0/1", i, empty, deq_rdy, deq_data); end
        end
        deq_en = 1'b0;
        y_rdy  = 1'b1;
        y_data = 1'b1;
        cyc();
        y_rdy = 1'b0;
        vectors++; if (deq_rdy !== 1'b1 || deq_data !== 1'b1) begin errors++; $display("FAIL ep_enq: got rdy=%b data=%b expected 1/1", deq_rdy, deq_data); end
        deq_en = 1'b1;
        cyc();
        deq_en = 1'b0;
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL ep_empty: got %b expected 1", empty); end
    endtask

    task automatic test_counters();
        logic [9:0] pat;
        pat = 10'b1011011010;
        do_reset();
        deq_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            y_rdy  = 1'b1;
            y_data = pat[i];
            cyc();
        end
        y_rdy = 1'b0;
        vectors++; if (total_count !== 4'd10 || ones_count !== 4'd6) begin errors++; $display("FAIL cnt_mix: got %0d/%0d expected 10/6", total_count, ones_count); end
        cyc();
        do_reset();
        deq_en = 1'b1;
        y_data = 1'b1;
        for (int i = 0; i < 20; i++) begin
            y_rdy = 1'b1;
            cyc();
            if (i == 13) begin
                vectors++; if (total_count !== 4'd14 || ones_count !== 4'd14) begin errors++; $display("FAIL cnt_pre_sat: got %0d/%0d expected 14/14", total_count, ones_count); end
            end
            if (i == 14) begin
                vectors++; if (total_count !== 4'd15 || ones_count !== 4'd15) begin errors++; $display("FAIL cnt_sat: got %0d/%0d expected 15/15", total_count, ones_count); end
            end
        end
        y_rdy = 1'b0;
        vectors++; if (total_count !== 4'd15 || ones_count !== 4'd15) begin errors++; $display("FAIL cnt_hold: got %0d/%0d expected 15/15", total_count, ones_count); end
        cyc();
        deq_en = 1'b0;
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL cnt_empty: got %b expected 1", empty); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        RST_N   = 1'b1;
        y_rdy   = 1'b0;
        y_data  = 1'b0;
        deq_en  = 1'b0;
        test_reset();
        test_reset_mid();
        test_fill_drain();
        test_wrap();
        test_full_pop();
        test_empty_pop();
        test_counters();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ifc_or_sink.md
# ifc_or_sink

Downstream consumer stage for the OR-gate interface block. It pulls each result from the producer's `y` method using the same `_data`/`_en`/`_rdy` method-port handshake and buffers the results in a DEPTH-entry FIFO. The buffered results are drained through a `deq` method. The block also keeps saturating counts of total results and of results equal to 1, for end-of-test checking.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 8, width of both statistics counters

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-high (port name kept per codebase; asserted = 1 resets this block)
- y_data  in  1  result value from producer `y` method
- y_rdy  in  1  producer has a valid result
- y_en  out  1  take strobe; result consumed on any edge with y_en=1
- deq_data  out  1  FIFO head value
- deq_rdy  out  1  FIFO non-empty
- deq_en  in  1  pop request; acted on only when deq_rdy=1
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- total_count  out  CNT_W  results accepted since reset, saturating
- ones_count  out  CNT_W  accepted results with y_data=1, saturating

## Operation
- Storage: DEPTH×1 register array, wr_ptr and rd_ptr of log2(DEPTH) bits, occupancy counter of log2(DEPTH)+1 bits.
- Pointer arithmetic: both pointers wrap modulo DEPTH.
- Enqueue fire: `enq = y_rdy & ~full & ~RST_N`. y_en is this same combinational term.
- On enq: mem[wr_ptr] ← y_data, wr_ptr++.
- Dequeue fire: `deq = deq_en & deq_rdy`. On deq: rd_ptr++.
- Occupancy: +1 on enq only, −1 on deq only, unchanged when both fire or neither fires.
- Status outputs:
  - deq_data = mem[rd_ptr], combinational read.
  - deq_rdy = ~empty.
  - empty = (occupancy==0); full = (occupancy==DEPTH).
- Full FIFO: y_en=0. No bypass; a deq in the same cycle does not enable an enq. The enq waits one cycle.
- Empty FIFO: deq_en is ignored; no pointer or occupancy change; deq_data holds the stale mem[rd_ptr] value.
- Simultaneous enq and deq at occupancy 1..DEPTH−1: both happen; occupancy unchanged.
- Statistics:
  - On enq, total_count++; if y_data=1, ones_count++.
  - Each counter saturates at 2^CNT_W−1 and holds; it does not wrap.
  - Counters are independent of deq.

## Timing
- Reset (RST_N=1, asynchronous, takes effect immediately):
  - wr_ptr=rd_ptr=occupancy=0; mem all 0.
  - empty=1, full=0, deq_rdy=0, deq_data=0, y_en=0, total_count=0, ones_count=0.
- Reset release: the first enq can occur on the first rising edge with RST_N=0.
- Reset asserted mid-operation discards all buffered entries and counts immediately. y_en drops to 0 in the same cycle, so the producer must not count that cycle as consumed.
- Enqueue-to-dequeue latency: an entry written on edge N is at deq_data with deq_rdy=1 after edge N (visible in cycle N+1).
- Throughput: one enq and one deq per cycle in steady state.
- After a full FIFO is popped, y_en rises in the cycle following that deq edge.
- y_en depends combinationally on y_rdy. It is the only input-to-output combinational path; no path from deq_en to y_en.

## Test plan
- Reset check: drive RST_N=1 mid-stream with 3 entries buffered -> same cycle empty=1, deq_rdy=0, y_en=0, both counts=0; after release, the first accepted value appears at deq_data one cycle later.
- Ordered fill and drain (DEPTH=4): enqueue 1,0,1,1 with deq_en=0 -> full=1 after 4th edge and y_en=0 while y_rdy=1; then deq_en=1 for 4 cycles -> deq_data sequence 1,0,1,1, empty=1 after the last pop.
- Pointer wrap: continuous enq plus deq for 10 cycles of alternating 0/1 -> output order matches input exactly; occupancy stays 1; full never asserts.
- Full with simultaneous pop: at full, y_rdy=1 and deq_en=1 for one cycle -> that cycle y_en=0, next cycle y_en=1; occupancy returns to 4.
- Empty pop: deq_en=1 while empty for 3 cycles -> no state change; next enq of 1 is read correctly.
- Counter saturation (CNT_W=4): 20 enqueues of y_data=1 while draining -> total_count=15 and ones_count=15, both holding; mix of 6 ones/4 zeros from reset -> total_count=10, ones_count=6.
